serial_magnitude_comparator: RTL and testbench

Bit-serial unsigned magnitude comparator that evaluates two WIDTH-bit operands one bit per clock, MSB first, using a single-bit compare slice (LT = ~a & b, Equal = a ~^ b). It terminates early at the first differing bit. It sits downstream of the operand registers and upstream of the control logic that consumes LT/Equal/GT and Done. The design trades latency for area against a parallel WIDTH-bit comparator.

---
 rtl/serial_magnitude_comparator.sv | 142 ++++++++++++++
 tb/tb_serial_magnitude_comparator.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator, MSB first, with early exit on the
// first differing bit.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for Start; results from the last compare are held
// SHIFT | comparing sa/sb MSBs, one bit position per cycle
// DONE  | one-cycle Done pulse; results are valid
module serial_magnitude_comparator #(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       Start,
  input  logic [WIDTH-1:0]           A,
  input  logic [WIDTH-1:0]           B,
  output logic                       Busy,
  output logic                       Done,
  output logic                       LT,
  output logic                       Equal,
  output logic                       GT,
  output logic [$clog2(WIDTH+1)-1:0] BitsUsed
);

  localparam int BW = $clog2(WIDTH + 1);
  // WIDTH=1 still needs a 1-bit counter so the compare below has an operand.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic [BW-1:0]    bits_q, bits_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic slice_lt;
  logic slice_eq;

  // Single-bit compare slice on the current MSBs.
  assign slice_lt = ~sa_q[WIDTH-1] & sb_q[WIDTH-1];
  assign slice_eq = sa_q[WIDTH-1] ~^ sb_q[WIDTH-1];

  // State, datapath and registered outputs; reset aborts any compare in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      bits_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      bits_q  <= bits_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-result logic; Busy/Done are precomputed from the
  // next state so both come straight off flops.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    bits_d  = bits_q;

    case (state_q)
      IDLE: begin
        if (Start) begin
          sa_d    = A;
          sb_d    = B;
          cnt_d   = '0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          bits_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!slice_eq) begin
          lt_d    = slice_lt;
          gt_d    = ~slice_lt;
          eq_d    = 1'b0;
          bits_d  = BW'(cnt_q) + BW'(1);
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          eq_d    = 1'b1;
          bits_d  = BW'(WIDTH);
          state_d = DONE;
        end else begin
          sa_d  = sa_q << 1;
          sb_d  = sb_q << 1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign LT       = lt_q;
  assign Equal    = eq_q;
  assign GT       = gt_q;
  assign BitsUsed = bits_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for serial_magnitude_comparator (16-bit and 1-bit builds).
module tb_serial_magnitude_comparator;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy, done, lt, eq, gt;
  logic [4:0]  bits;

  logic        start1;
  logic [0:0]  a1;
  logic [0:0]  b1;
  logic        busy1, done1, lt1, eq1, gt1;
  logic [0:0]  bits1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       lt;
    logic       eq;
    logic       gt;
    logic [4:0] bits;
    int         k;
  } exp_t;

  exp_t sbq[$];
  exp_t cur_e;
  logic cur_valid = 1'b0;
  int   m_left = 0;

  serial_magnitude_comparator #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .Start(start), .A(a), .B(b),
    .Busy(busy), .Done(done), .LT(lt), .Equal(eq), .GT(gt), .BitsUsed(bits)
  );

  serial_magnitude_comparator #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .Start(start1), .A(a1), .B(b1),
    .Busy(busy1), .Done(done1), .LT(lt1), .Equal(eq1), .GT(gt1), .BitsUsed(bits1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: scan from the MSB for the first differing bit.
  function automatic exp_t model16(input logic [15:0] ma, input logic [15:0] mb);
    exp_t e;
    logic found;
    found  = 1'b0;
    e.lt   = 1'b0;
    e.eq   = 1'b1;
    e.gt   = 1'b0;
    e.bits = 5'd16;
    e.k    = 15;
    for (int i = 15; i >= 0; i--) begin
      if (!found && (ma[i] != mb[i])) begin
        found  = 1'b1;
        e.lt   = mb[i];
        e.gt   = ma[i];
        e.eq   = 1'b0;
        e.bits = 5'(16 - i);
        e.k    = 15 - i;
      end
    end
    return e;
  endfunction

  // Per-cycle check of the 16-bit DUT against the model, then advance the
  // model to the next rising edge (inputs are stable at this point).
  always @(negedge clk) begin
    if (reset) begin
      m_left    = 0;
      cur_valid = 1'b0;
      sbq.delete();
    end else begin
      chk("busy", busy, (m_left > 0));
      chk("done", done, (m_left == 1));
      if (m_left == 1 && sbq.size() > 0) begin
        cur_e     = sbq.pop_front();
        cur_valid = 1'b1;
        chk("res_lt", lt, cur_e.lt);
        chk("res_eq", eq, cur_e.eq);
        chk("res_gt", gt, cur_e.gt);
        chk("res_bits", bits, cur_e.bits);
      end else if (m_left > 1) begin
        chk("clr_flags", {lt, eq, gt}, 3'b000);
        chk("clr_bits", bits, 5'd0);
      end else if (m_left == 0 && cur_valid) begin
        chk("hold_flags", {lt, eq, gt}, {cur_e.lt, cur_e.eq, cur_e.gt});
        chk("hold_bits", bits, cur_e.bits);
      end
      if (m_left > 0) begin
        m_left = m_left - 1;
      end else if (start) begin
        exp_t e;
        e = model16(a, b);
        sbq.push_back(e);
        m_left = e.k + 2;
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (m_left != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (m_left != 0) chk("wait_idle_timeout", m_left, 0);
  endtask

  task automatic run_op(input logic [15:0] va, input logic [15:0] vb);
    @(posedge clk); #2;
    start = 1'b1; a = va; b = vb;
    @(posedge clk); #2;
    start = 1'b0;
    wait_idle();
    @(posedge clk); #2;
  endtask

  task automatic run1(input logic va, input logic vb,
                      input logic elt, input logic eeq, input logic egt);
    @(posedge clk); #2;
    start1 = 1'b1; a1 = va; b1 = vb;
    @(posedge clk); #2;
    start1 = 1'b0; a1 = ~va; b1 = ~vb;
    @(negedge clk);
    chk("w1_shift_busy", busy1, 1'b1);
    chk("w1_shift_done", done1, 1'b0);
    @(negedge clk);
    chk("w1_done", done1, 1'b1);
    chk("w1_busy", busy1, 1'b1);
    chk("w1_flags", {lt1, eq1, gt1}, {elt, eeq, egt});
    chk("w1_bits", bits1, 1'b1);
    @(negedge clk);
    chk("w1_done_low", done1, 1'b0);
    chk("w1_idle", busy1, 1'b0);
    chk("w1_hold", {lt1, eq1, gt1}, {elt, eeq, egt});
  endtask

  initial begin
    logic [15:0] ra, rb, onebit;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    onebit = 16'h0001;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_outs", {busy, done, lt, eq, gt}, 5'b0);
    chk("rst_bits", bits, 5'd0);
    chk("rst_outs_w1", {busy1, done1, lt1, eq1, gt1, bits1}, 6'b0);
    reset = 1'b0;

    run_op(16'h8000, 16'h7FFF);
    chk("msb_gt", {lt, eq, gt}, 3'b001);
    chk("msb_bits", bits, 5'd1);

    run_op(16'h1234, 16'h1234);
    chk("eq_flags", {lt, eq, gt}, 3'b010);
    chk("eq_bits", bits, 5'd16);

    run_op(16'h0001, 16'h0002);
    repeat (3) @(posedge clk);
    #2;
    chk("bit1_lt_held", {lt, eq, gt}, 3'b100);
    chk("bit1_bits_held", bits, 5'd15);

    // Start held high: back-to-back accepts with one IDLE cycle between.
    @(posedge clk); #2;
    start = 1'b1; a = 16'hFFFF; b = 16'h0000;
    repeat (10) @(posedge clk);
    #2;
    start = 1'b0;
    wait_idle();
    @(posedge clk); #2;
    chk("held_gt", {lt, eq, gt}, 3'b001);

    // Start pulses and operand changes while busy must be ignored.
    @(posedge clk); #2;
    start = 1'b1; a = 16'h0F00; b = 16'h0F01;
    @(posedge clk); #2;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      start = (i % 2 == 0);
      a = 16'($urandom);
      b = 16'($urandom);
    end
    start = 1'b0;
    wait_idle();
    @(posedge clk); #2;
    chk("busy_ign_lt", {lt, eq, gt}, 3'b100);
    chk("busy_ign_bits", bits, 5'd16);

    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = (i % 2 == 1) ? (ra ^ (onebit << $urandom_range(0, 15))) : 16'($urandom);
      if (i == 6) rb = ra;
      run_op(ra, rb);
    end

    // Reset in the middle of a long (equal) compare.
    @(posedge clk); #2;
    start = 1'b1; a = 16'h00F0; b = 16'h00F0;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("pre_rst_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("async_rst_outs", {busy, done, lt, eq, gt}, 5'b0);
    chk("async_rst_bits", bits, 5'd0);
    @(posedge clk); #2;
    chk("rst_hold_outs", {busy, done, lt, eq, gt}, 5'b0);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    chk("no_done_after_rst", {done, eq, bits}, 7'b0);

    run_op(16'h0000, 16'h0001);
    chk("post_rst_lt", {lt, eq, gt}, 3'b100);
    chk("post_rst_bits", bits, 5'd16);

    run1(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run1(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    run1(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run1(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
